// File: rtl/hi_xcorr_pkg.sv
// Shared definitions for the HF I/Q cross-correlator: rate encodings, window geometry,
// elaboration-time sanity checks and the signed saturation helper.
package hi_xcorr_pkg;

    localparam logic [1:0] RATE_D2  = 2'd0;
    localparam logic [1:0] RATE_D4  = 2'd1;
    localparam logic [1:0] RATE_D8  = 2'd2;
    localparam logic [1:0] RATE_D16 = 2'd3;

    function automatic int unsigned window_len(input int unsigned cyc, input int unsigned half_log2);
        return cyc << (half_log2 + 1);
    endfunction

    function automatic int unsigned bit_period(input int unsigned w, input int unsigned out_w);
        return w / (2 * out_w);
    endfunction

    function automatic bit is_pow2_ge2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit acc_fits(input int unsigned acc_w, input int unsigned adc_w,
                                    input int unsigned w);
        return acc_w >= adc_w + $clog2(w) + 1;
    endfunction

    // Clamp v into the n-bit two's complement range; result is sign-extended to 64 bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/hi_am_hysteresis.sv
// AM hysteresis bit: set by a full-scale sample, cleared by a zero sample, and forced
// high again after HYST_TIMEOUT consecutive samples spent low.
module hi_am_hysteresis
    import hi_xcorr_pkg::*;
#(
    parameter int unsigned ADC_W        = 8,
    parameter int unsigned HYST_TIMEOUT = 4095
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [ADC_W-1:0] i_adc,
    output logic             o_am
);

    localparam int unsigned CNT_W = $clog2(HYST_TIMEOUT + 1);

    logic             r_am;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_am  <= 1'b0;
            r_cnt <= '0;
        end else if (i_en) begin
            if (&i_adc) begin
                r_am  <= 1'b1;
                r_cnt <= '0;
            end else if (~|i_adc || !r_am) begin
                // this sample is spent low; the timeout sample itself re-arms the bit
                if (r_cnt == CNT_W'(HYST_TIMEOUT - 1)) begin
                    r_am  <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_am  <= 1'b0;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_am = r_am;

endmodule

// File: rtl/hi_xcorr_iq_gen.sv
// HF reader I/Q cross-correlator: divides the carrier into an ADC clock, correlates samples
// against square-wave I/Q subcarrier references and shifts saturated window results out over SSP.
module hi_xcorr_iq_gen
    import hi_xcorr_pkg::*;
#(
    parameter int unsigned ADC_W        = 8,
    parameter int unsigned HALF_LOG2    = 3,
    parameter int unsigned CYC_PER_RPT  = 4,
    parameter int unsigned ACC_W        = 16,
    parameter int unsigned OUT_W        = 8,
    parameter int unsigned SHIFT        = 6,
    parameter int unsigned HYST_TIMEOUT = 4095
) (
    input  logic             ck_1356meg,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_d,
    input  logic [1:0]       rate_sel,
    input  logic             snoop,
    output logic             adc_clk,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din,
    output logic             dbg
);

    localparam int unsigned W    = window_len(CYC_PER_RPT, HALF_LOG2);
    localparam int unsigned B    = bit_period(W, OUT_W);
    localparam int unsigned K_W  = $clog2(W);
    localparam int unsigned BL   = $clog2(B);
    localparam int unsigned SR_W = 2 * OUT_W;

    if (!is_pow2_ge2(B) || (B * SR_W != W)) begin : g_bad_bit_period
        $error("hi_xcorr_iq_gen: W/(2*OUT_W) must be a power of two >= 2 (W=%0d)", W);
    end
    if (!acc_fits(ACC_W, ADC_W, W)) begin : g_bad_acc_w
        $error("hi_xcorr_iq_gen: ACC_W=%0d too narrow for window of %0d samples", ACC_W, W);
    end
    if (HALF_LOG2 < 1) begin : g_bad_half
        $error("hi_xcorr_iq_gen: HALF_LOG2 must be >= 1");
    end

    logic [3:0] r_p;
    logic [1:0] r_rate;
    logic       r_adc_clk;
    logic [3:0] w_p_last;
    logic [3:0] w_half;
    logic       w_sample_en;

    always_comb begin
        w_p_last = 4'd1;
        w_half   = 4'd1;
        case (r_rate)
            RATE_D2:  begin w_p_last = 4'd1;  w_half = 4'd1; end
            RATE_D4:  begin w_p_last = 4'd3;  w_half = 4'd2; end
            RATE_D8:  begin w_p_last = 4'd7;  w_half = 4'd4; end
            default:  begin w_p_last = 4'd15; w_half = 4'd8; end
        endcase
    end

    assign w_sample_en = (r_p == w_half);

    // rate_sel is only taken at the period wrap so an adc_clk period is never cut short
    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            r_p       <= '0;
            r_rate    <= rate_sel;
            r_adc_clk <= 1'b0;
        end else begin
            r_adc_clk <= (r_p < w_half);
            if (r_p == w_p_last) begin
                r_p    <= '0;
                r_rate <= rate_sel;
            end else begin
                r_p <= r_p + 4'd1;
            end
        end
    end

    logic [K_W-1:0]          r_k;
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic signed [ACC_W-1:0] w_x;
    logic [K_W-1:0]          w_k_q;
    logic                    w_sign_i;
    logic                    w_sign_q;
    logic signed [ACC_W-1:0] w_sh_i;
    logic signed [ACC_W-1:0] w_sh_q;
    logic [OUT_W-1:0]        w_rep_i;
    logic [OUT_W-1:0]        w_rep_q;
    logic                    w_am;
    logic                    r_am_prev;

    assign w_x      = ACC_W'(adc_d);
    assign w_k_q    = r_k + K_W'(1 << (HALF_LOG2 - 1));
    assign w_sign_i = r_k[HALF_LOG2];
    assign w_sign_q = w_k_q[HALF_LOG2];
    assign w_sh_i   = r_acc_i >>> SHIFT;
    assign w_sh_q   = r_acc_q >>> SHIFT;

    always_comb begin
        if (snoop) begin
            w_rep_i = {(OUT_W-1)'(sat(64'(w_sh_i), OUT_W - 1)), r_am_prev};
            w_rep_q = {(OUT_W-1)'(sat(64'(w_sh_q), OUT_W - 1)), w_am};
        end else begin
            w_rep_i = OUT_W'(sat(64'(w_sh_i), OUT_W));
            w_rep_q = OUT_W'(sat(64'(w_sh_q), OUT_W));
        end
    end

    hi_am_hysteresis #(
        .ADC_W       (ADC_W),
        .HYST_TIMEOUT(HYST_TIMEOUT)
    ) u_am (
        .i_clk  (ck_1356meg),
        .i_reset(reset),
        .i_en   (w_sample_en),
        .i_adc  (adc_d),
        .o_am   (w_am)
    );

    logic [SR_W-1:0] r_sr;
    logic            r_ssp_clk;
    logic            r_frame;
    logic [BL-1:0]   w_kb;

    assign w_kb = r_k[BL-1:0];

    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            r_k       <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            r_am_prev <= 1'b0;
            r_sr      <= '0;
            r_ssp_clk <= 1'b0;
            r_frame   <= 1'b0;
        end else if (w_sample_en) begin
            if (r_k == '0) begin
                r_acc_i <= w_x;
                r_acc_q <= w_x;
            end else begin
                r_acc_i <= w_sign_i ? r_acc_i - w_x : r_acc_i + w_x;
                r_acc_q <= w_sign_q ? r_acc_q - w_x : r_acc_q + w_x;
            end
            r_k <= (r_k == K_W'(W - 1)) ? '0 : r_k + K_W'(1);

            if (r_k == K_W'(W / 2 - 1)) r_am_prev <= w_am;

            if (r_k == '0) begin
                r_sr <= {w_rep_i, w_rep_q};
            end else if (w_kb == '0) begin
                r_sr <= {r_sr[SR_W-2:0], 1'b0};
            end
            if (w_kb == '0) begin
                r_ssp_clk <= 1'b1;
            end else if (w_kb == BL'(B / 2)) begin
                r_ssp_clk <= 1'b0;
            end
            r_frame <= (r_k < K_W'(B));
        end
    end

    assign adc_clk   = r_adc_clk;
    assign ssp_clk   = r_ssp_clk;
    assign ssp_frame = r_frame;
    assign ssp_din   = r_sr[SR_W-1];
    assign dbg       = r_k[HALF_LOG2];

endmodule

// File: tb/tb_hi_xcorr_iq_gen.sv
// Scoreboard bench for hi_xcorr_iq_gen: default instance plus a SHIFT=5 instance driven in
// parallel; expected reports come from a window-sum model and are checked by SSP monitors.
module tb_hi_xcorr_iq_gen;

    localparam int W  = 64;
    localparam int B  = 4;
    localparam int NI = 2;

    logic          ck       = 1'b0;
    logic          reset    = 1'b1;
    logic [7:0]    adc_d    = 8'd0;
    logic [1:0]    rate_sel = 2'd0;
    logic          snoop    = 1'b0;
    logic [NI-1:0] w_adc_clk;
    logic [NI-1:0] w_ssp_clk;
    logic [NI-1:0] w_ssp_frame;
    logic [NI-1:0] w_ssp_din;
    logic [NI-1:0] w_dbg;

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    hi_xcorr_iq_gen dut0 (
        .ck_1356meg(ck), .reset(reset), .adc_d(adc_d), .rate_sel(rate_sel), .snoop(snoop),
        .adc_clk(w_adc_clk[0]), .ssp_clk(w_ssp_clk[0]), .ssp_frame(w_ssp_frame[0]),
        .ssp_din(w_ssp_din[0]), .dbg(w_dbg[0])
    );

    hi_xcorr_iq_gen #(.SHIFT(5)) dut1 (
        .ck_1356meg(ck), .reset(reset), .adc_d(adc_d), .rate_sel(rate_sel), .snoop(snoop),
        .adc_clk(w_adc_clk[1]), .ssp_clk(w_ssp_clk[1]), .ssp_frame(w_ssp_frame[1]),
        .ssp_din(w_ssp_din[1]), .dbg(w_dbg[1])
    );

    // Reference model: the samples of the current window plus the AM hysteresis state.
    int win[W];
    int kk;
    int am_m;
    int am_prev_m;
    int low_run;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int sat_n(input int v, input int n);
        int hi;
        int lo;
        hi = (1 << (n - 1)) - 1;
        lo = -(1 << (n - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic logic [15:0] model_report(input int sh, input logic sn);
        int ai;
        int aq;
        int si;
        int sq;
        logic [7:0] ri;
        logic [7:0] rq;
        ai = 0;
        aq = 0;
        for (int k = 0; k < W; k++) begin
            ai += (((k / 8) % 2) == 1) ? -win[k] : win[k];
            aq += ((((k + 4) / 8) % 2) == 1) ? -win[k] : win[k];
        end
        si = ai >>> sh;
        sq = aq >>> sh;
        if (sn) begin
            ri = {7'(sat_n(si, 7)), 1'(am_prev_m)};
            rq = {7'(sat_n(sq, 7)), 1'(am_m)};
        end else begin
            ri = 8'(sat_n(si, 8));
            rq = 8'(sat_n(sq, 8));
        end
        return {ri, rq};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < W; k++) win[k] = 0;
        kk = 0;
        am_m = 0;
        am_prev_m = 0;
        low_run = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic model_sample(input int v);
        if (kk == 0) begin
            q0.push_back(model_report(6, snoop));
            q1.push_back(model_report(5, snoop));
        end
        win[kk] = v;
        if (kk == W / 2 - 1) am_prev_m = am_m;
        if (v == 255) begin
            am_m = 1;
            low_run = 0;
        end else if (v == 0 || am_m == 0) begin
            low_run++;
            am_m = (low_run == 4095) ? 1 : 0;
            if (low_run == 4095) low_run = 0;
        end
        kk = (kk + 1) % W;
    endtask

    task automatic next_sample(input logic [7:0] v, output int cyc);
        logic old;
        int kcap;
        old = 1'b0;
        adc_d = v;
        cyc = 0;
        do begin
            @(posedge ck);
            old = w_adc_clk[0];
            #1;
            cyc++;
        end while (!(old && !w_adc_clk[0]) && cyc < 40);
        if (!(old && !w_adc_clk[0])) begin
            checks++;
            errors++;
            $display("FAIL sample_timeout: no adc_clk fall within %0d clocks", cyc);
        end
        kcap = kk;
        model_sample(int'(v));
        for (int i = 0; i < NI; i++) begin
            chk("ssp_frame", 32'(w_ssp_frame[i]), 32'(kcap < B));
            chk("ssp_clk", 32'(w_ssp_clk[i]), 32'((kcap % B) < B / 2));
            chk("dbg", 32'(w_dbg[i]), 32'((kk / 8) % 2));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_adc_clk"}, 32'(w_adc_clk[i]), 32'd0);
            chk({tag, "_ssp_clk"}, 32'(w_ssp_clk[i]), 32'd0);
            chk({tag, "_ssp_frame"}, 32'(w_ssp_frame[i]), 32'd0);
            chk({tag, "_ssp_din"}, 32'(w_ssp_din[i]), 32'd0);
            chk({tag, "_dbg"}, 32'(w_dbg[i]), 32'd0);
        end
    endtask

    task automatic check_word(input int id, input logic [15:0] got);
        logic [15:0] e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL report%0d: got 0x%04h with no report expected", id, got);
        end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("report%0d", id), 32'(got), 32'(e));
        end
    endtask

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 3))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_mon
        initial begin
            logic prev_clk;
            int nb;
            logic [15:0] word;
            prev_clk = 1'b0;
            nb = 0;
            word = '0;
            forever begin
                @(negedge ck);
                if (reset) begin
                    nb = 0;
                    prev_clk = 1'b0;
                end else begin
                    if (w_ssp_clk[g] && !prev_clk) begin
                        if (w_ssp_frame[g]) begin
                            chk($sformatf("frame_align%0d", g), 32'(nb), 32'd0);
                            nb = 0;
                        end
                        if (w_ssp_frame[g] || nb > 0) begin
                            word = {word[14:0], w_ssp_din[g]};
                            nb++;
                            if (nb == 16) begin
                                check_word(g, word);
                                nb = 0;
                            end
                        end
                    end
                    prev_clk = w_ssp_clk[g];
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int rates[4];
        rates = '{3, 1, 2, 0};
        model_reset();
        repeat (3) @(posedge ck);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        repeat (3 * W) next_sample(8'd128, c);
        repeat (2 * W) next_sample(((kk % 16) < 8) ? 8'd255 : 8'd0, c);
        repeat (2 * W) next_sample(((kk % 16) < 8) ? 8'd0 : 8'd255, c);
        repeat (4 * W) next_sample(rnd8(), c);

        snoop = 1'b1;
        repeat (2 * W) next_sample(8'd255, c);
        while (kk != 1) next_sample(8'd255, c);
        repeat (4095 + 2 * W) next_sample(8'd0, c);
        repeat (3 * W) next_sample(rnd8(), c);

        snoop = 1'b0;
        repeat (W) next_sample(rnd8(), c);
        while (kk != 37) next_sample(rnd8(), c);
        reset = 1'b1;
        model_reset();
        @(posedge ck);
        #1;
        check_outputs_zero("midreset");
        reset = 1'b0;
        repeat (3 * W) next_sample(rnd8(), c);

        foreach (rates[r]) begin
            rate_sel = 2'(rates[r]);
            repeat (2) next_sample(rnd8(), c);
            repeat (70) begin
                next_sample(rnd8(), c);
                chk($sformatf("adc_period_rate%0d", rates[r]), 32'(c), 32'(2 << rates[r]));
            end
        end
        repeat (W + 8) next_sample(rnd8(), c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
